// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operand-fetch / write-back stage.
// Holds the datapath widths, register-file geometry and the ALU opcode values.
// The issue stage treats opcodes as opaque and only carries them through.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned ADDR_W = $clog2(NREGS);
  localparam int unsigned CTRL_W = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CTRL_W-1:0] ctrl_t;

  // ALU opcodes, decoded only inside the ALU itself.
  localparam ctrl_t AluOpAdd = 2'b00;
  localparam ctrl_t AluOpSub = 2'b01;
  localparam ctrl_t AluOpAnd = 2'b10;
  localparam ctrl_t AluOpOr  = 2'b11;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction-issue bus into the ALU issue stage (valid/ready handshake).
//   in_valid   producer offers an instruction
//   in_ready   stage can accept this cycle
//   in_ctrl    ALU opcode (opaque)
//   in_rd      destination register
//   in_rs1     source register for ALU a
//   in_rs2     source register for ALU b (ignored when in_imm_en=1)
//   in_imm_en  select in_imm as ALU b
//   in_imm     immediate operand
// Modports: master = instruction producer, slave = issue stage.
interface alu_issue_stage_if
  import alu_pkg::*;
();

  logic  in_valid;
  logic  in_ready;
  ctrl_t in_ctrl;
  addr_t in_rd;
  addr_t in_rs1;
  addr_t in_rs2;
  logic  in_imm_en;
  data_t in_imm;

  modport master (
    output in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    output in_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file for the ALU issue stage.
// Two combinational operand read ports, one combinational debug read port,
// one synchronous write port, asynchronous active-low clear. r0 reads as zero
// and ignores writes.
// Ports:
//   clk, rst_n          clock, async active-low clear
//   ra_addr_i/ra_data_o operand A read port
//   rb_addr_i/rb_data_o operand B read port
//   dbg_addr_i/dbg_data_o debug read port
//   we_i, waddr_i, wdata_i write port (takes effect at the rising edge)
module alu_regfile
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  addr_t ra_addr_i,
  output data_t ra_data_o,
  input  addr_t rb_addr_i,
  output data_t rb_data_o,
  input  addr_t dbg_addr_i,
  output data_t dbg_data_o,
  input  logic  we_i,
  input  addr_t waddr_i,
  input  data_t wdata_i
);

  data_t mem_q [NREGS];
  data_t mem_d [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i && (waddr_i != '0)) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Address 0 is forced to zero on every read port.
  always_comb begin
    ra_data_o  = (ra_addr_i == '0) ? '0 : mem_q[ra_addr_i];
    rb_data_o  = (rb_addr_i == '0) ? '0 : mem_q[rb_addr_i];
    dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch / write-back stage around the 8-bit ALU.
// Accepts one register-form instruction per cycle, reads operands from the
// register file (with forwarding of the in-flight ALU result), drives the ALU
// from pipeline registers and writes the ALU result back one cycle later.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   hold           freeze the pipeline (no accept, no write-back)
//   in_if          instruction issue bus (slave side)
//   alu_a/b/ctrl   registered ALU operands and opcode
//   alu_result     combinational ALU output
//   wb_valid/rd/data  one-cycle write-back report
//   dbg_addr/data  debug register read, no forwarding
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  alu_issue_stage_if.slave         in_if,
  output data_t                    alu_a,
  output data_t                    alu_b,
  output ctrl_t                    alu_ctrl,
  input  data_t                    alu_result,
  output logic                     wb_valid,
  output addr_t                    wb_rd,
  output data_t                    wb_data,
  input  addr_t                    dbg_addr,
  output data_t                    dbg_data
);

  logic  ex_valid_q, ex_valid_d;
  addr_t ex_rd_q,    ex_rd_d;
  data_t alu_a_q,    alu_a_d;
  data_t alu_b_q,    alu_b_d;
  ctrl_t alu_ctrl_q, alu_ctrl_d;
  logic  wb_valid_q, wb_valid_d;
  addr_t wb_rd_q,    wb_rd_d;
  data_t wb_data_q,  wb_data_d;

  data_t rf_a, rf_b;
  data_t opnd_a, opnd_b;
  logic  accept;
  logic  rf_we;

  assign in_if.in_ready = !hold;
  assign accept         = in_if.in_valid && !hold;
  // The ALU output is only committed while the pipeline advances.
  assign rf_we          = ex_valid_q && !hold;

  alu_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_addr_i  (in_if.in_rs1),
    .ra_data_o  (rf_a),
    .rb_addr_i  (in_if.in_rs2),
    .rb_data_o  (rf_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
    .we_i       (rf_we),
    .waddr_i    (ex_rd_q),
    .wdata_i    (alu_result)
  );

  // Operand select: r0 is zero, then the in-flight result, then the register file.
  // Forwarding covers the same-edge write-back, so no stale value is ever read.
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (in_if.in_rs1 == '0) begin
      opnd_a = '0;
    end else if (ex_valid_q && (ex_rd_q == in_if.in_rs1)) begin
      opnd_a = alu_result;
    end
    if (in_if.in_imm_en) begin
      opnd_b = in_if.in_imm;
    end else if (in_if.in_rs2 == '0) begin
      opnd_b = '0;
    end else if (ex_valid_q && (ex_rd_q == in_if.in_rs2)) begin
      opnd_b = alu_result;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (!hold) begin
      ex_valid_d = accept;
      if (accept) begin
        ex_rd_d    = in_if.in_rd;
        alu_a_d    = opnd_a;
        alu_b_d    = opnd_b;
        alu_ctrl_d = in_if.in_ctrl;
      end
      // An r0 destination still reports write-back even though nothing is stored.
      if (ex_valid_q) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = ex_rd_q;
        wb_data_d  = alu_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_ctrl = alu_ctrl_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with an adder standing in for the ALU.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  hold;
  data_t alu_a, alu_b, alu_result, wb_data, dbg_data;
  ctrl_t alu_ctrl;
  logic  wb_valid;
  addr_t wb_rd, dbg_addr;

  int errors = 0;
  int checks = 0;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .in_if      (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  assign alu_result = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input addr_t rd, input addr_t rs1, input addr_t rs2,
                       input logic imm_en, input data_t imm);
    bus.in_valid  = v;
    bus.in_ctrl   = AluOpAdd;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm_en = imm_en;
    bus.in_imm    = imm;
  endtask

  task automatic dbg_check(input string tag, input addr_t a, input data_t exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    hold     = 1'b0;
    dbg_addr = '0;
    issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    #12;
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_in_ready", bus.in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    // Immediate into r1.
    issue(1'b1, 3'd1, 3'd0, 3'd0, 1'b1, 8'h24);
    step();
    check("imm_alu_a", alu_a, 8'h00);
    check("imm_alu_b", alu_b, 8'h24);
    check("imm_no_wb_yet", wb_valid, 1'b0);

    // Dependent r2 = r1 + r1, both operands forwarded.
    issue(1'b1, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00);
    step();
    check("imm_wb_valid", wb_valid, 1'b1);
    check("imm_wb_rd", wb_rd, 3'd1);
    check("imm_wb_data", wb_data, 8'h24);
    check("fwd_alu_a", alu_a, 8'h24);
    check("fwd_alu_b", alu_b, 8'h24);
    dbg_check("imm_dbg_r1", 3'd1, 8'h24);

    // r0 destination.
    issue(1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 8'h55);
    step();
    check("fwd_wb_valid", wb_valid, 1'b1);
    check("fwd_wb_rd", wb_rd, 3'd2);
    check("fwd_wb_data", wb_data, 8'h48);
    check("r0_alu_b", alu_b, 8'h55);
    issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    step();
    check("r0_wb_valid", wb_valid, 1'b1);
    check("r0_wb_rd", wb_rd, 3'd0);
    check("r0_wb_data", wb_data, 8'h55);
    dbg_check("r0_dbg", 3'd0, 8'h00);
    dbg_check("r2_dbg", 3'd2, 8'h48);

    // Read of r0 after the r0 write, then hold with it in EX.
    issue(1'b1, 3'd4, 3'd0, 3'd0, 1'b1, 8'h07);
    step();
    check("r0_read_alu_a", alu_a, 8'h00);
    check("hold_pre_alu_b", alu_b, 8'h07);
    check("hold_pre_wb", wb_valid, 1'b0);
    hold = 1'b1;
    issue(1'b1, 3'd5, 3'd1, 3'd0, 1'b1, 8'h09);
    #1;
    check("hold_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_wb_valid", wb_valid, 1'b0);
      check("hold_alu_a", alu_a, 8'h00);
      check("hold_alu_b", alu_b, 8'h07);
      dbg_check("hold_dbg_r4", 3'd4, 8'h00);
    end
    hold = 1'b0;
    issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    step();
    check("release_wb_valid", wb_valid, 1'b1);
    check("release_wb_rd", wb_rd, 3'd4);
    check("release_wb_data", wb_data, 8'h07);
    step();
    check("release_no_dup", wb_valid, 1'b0);
    dbg_check("release_dbg_r4", 3'd4, 8'h07);
    dbg_check("held_instr_dropped_r5", 3'd5, 8'h00);

    // Eight back-to-back increments of r3.
    issue(1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("stream_alu_a", alu_a, i - 1);
      if (i >= 2) begin
        check("stream_wb_valid", wb_valid, 1'b1);
        check("stream_wb_data", wb_data, i - 1);
      end
    end
    issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    step();
    check("stream_last_wb_valid", wb_valid, 1'b1);
    check("stream_last_wb_data", wb_data, 8'h08);
    dbg_check("stream_dbg_r3", 3'd3, 8'h08);
    step();
    check("stream_done", wb_valid, 1'b0);

    // Mid-stream reset discards the in-flight instruction.
    issue(1'b1, 3'd6, 3'd3, 3'd0, 1'b1, 8'h33);
    step();
    check("pre_rst_alu_a", alu_a, 8'h08);
    issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wb_valid", wb_valid, 1'b0);
    check("mid_rst_alu_a", alu_a, 8'h00);
    check("mid_rst_alu_b", alu_b, 8'h00);
    for (int i = 0; i < 8; i++) begin
      dbg_check("mid_rst_dbg", addr_t'(i), 8'h00);
    end
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_wb_valid", wb_valid, 1'b0);
    dbg_check("post_rst_r6", 3'd6, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
